// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM states, byte-mask and alignment helpers.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned RD_W   = 5;

    localparam logic [1:0] LSU_B = 2'd0;
    localparam logic [1:0] LSU_H = 2'd1;
    localparam logic [1:0] LSU_W = 2'd2;
    localparam logic [1:0] LSU_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Byte-enable mask for an access of the given size at byte offset off.
    function automatic logic [MASK_W-1:0] lsu_wmask(input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
        logic [MASK_W-1:0] base;
        case (size)
            LSU_B:   base = 8'h01;
            LSU_H:   base = 8'h03;
            LSU_W:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] low;
        case (size)
            LSU_B:   low = 3'b000;
            LSU_H:   low = 3'b001;
            LSU_W:   low = 3'b011;
            LSU_D:   low = 3'b111;
            default: low = 3'b111;
        endcase
        return |(off & low);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: shift to byte offset, then sign/zero-extend by size.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0]   rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [TYPE_W-1:0] lsu_type,
    output logic [XLEN-1:0]   data_c
);

    logic [XLEN-1:0] shifted;
    logic            sgn;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        sgn     = ~lsu_type[2];
        data_c  = shifted;
        case (lsu_type[1:0])
            LSU_B:   data_c = {{56{sgn & shifted[7]}},  shifted[7:0]};
            LSU_H:   data_c = {{48{sgn & shifted[15]}}, shifted[15:0]};
            LSU_W:   data_c = {{32{sgn & shifted[31]}}, shifted[31:0]};
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage LSU front end: EX handshake -> aligned memory request -> extended result to WB.
// Optional WAIT watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_addr,
    input  logic              in_wen,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [TYPE_W-1:0] in_lsu_type,
    input  logic [RD_W-1:0]   in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_misalign,
    output logic              out_timeout
);

    lsu_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              req_valid_q, req_valid_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   align_data_c;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    // Watchdog limit has no effect when the watchdog is compiled out.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    lsu_load_align u_align (
        .rdata    (mem_rdata),
        .off      (off_q),
        .lsu_type (type_q),
        .data_c   (align_data_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        off_d      = off_q;
        type_d     = type_q;
        rd_d       = rd_q;
        data_d     = data_q;
        misalign_d = misalign_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d     = {in_addr[XLEN-1:3], 3'b000};
                    wen_d      = in_wen;
                    wdata_d    = in_wdata << {in_addr[2:0], 3'b000};
                    wmask_d    = lsu_wmask(in_lsu_type[1:0], in_addr[2:0]);
                    off_d      = in_addr[2:0];
                    type_d     = in_lsu_type;
                    rd_d       = in_rd;
                    data_d     = '0;
                    misalign_d = lsu_misaligned(in_lsu_type[1:0], in_addr[2:0]);
`ifdef LSU_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = misalign_d ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = wen_q ? ST_RESP : ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = align_data_c;
                    state_d = ST_RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        req_valid_d = (state_d == ST_REQ);
        out_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            off_q       <= '0;
            type_q      <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            in_ready_q  <= in_ready_d;
            req_valid_q <= req_valid_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            off_q       <= off_d;
            type_q      <= type_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            misalign_q  <= misalign_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign out_valid     = out_valid_q;
    assign out_data      = data_q;
    assign out_rd        = rd_q;
    assign out_misalign  = misalign_q;
`ifdef LSU_TIMEOUT_EN
    assign out_timeout   = timeout_q;
`else
    assign out_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage; the watchdog case runs only when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic        in_wen;
    logic [63:0] in_wdata;
    logic [2:0]  in_lsu_type;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misalign;
    logic        out_timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wen         (in_wen),
        .in_wdata       (in_wdata),
        .in_lsu_type    (in_lsu_type),
        .in_rd          (in_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .out_misalign   (out_misalign),
        .out_timeout    (out_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Aligned load with mem_req_ready=1 and response one cycle after the handshake.
    task automatic run_load(input string tag, input logic [63:0] addr, input logic [2:0] typ,
                            input logic [4:0] rd, input logic [63:0] rdata,
                            input logic [63:0] exp_maddr, input logic [63:0] exp_data);
        @(negedge clock);
        in_valid = 1'b1; in_addr = addr; in_wen = 1'b0; in_lsu_type = typ; in_rd = rd;
        mem_req_ready = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, "_mem_addr"}, mem_addr, exp_maddr);
        chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        @(negedge clock);
        chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        mem_resp_valid = 1'b1; mem_rdata = rdata;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_out_data"}, out_data, exp_data);
        chk({tag, "_out_rd"}, 64'(out_rd), 64'(rd));
        chk({tag, "_misalign"}, 64'(out_misalign), 64'd0);
        @(negedge clock);
        chk({tag, "_idle_again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wen = 1'b0; in_wdata = '0;
        in_lsu_type = '0; in_rd = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = '0; out_ready = 1'b1;

        repeat (2) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("rst_out_timeout", 64'(out_timeout), 64'd0);
        reset_n = 1'b1;

        run_load("lb",  64'h8000_0003, 3'b000, 5'd5,  64'h0000_0000_8000_0000,
                 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lbu", 64'h8000_0003, 3'b100, 5'd6,  64'h0000_0000_8000_0000,
                 64'h8000_0000, 64'h0000_0000_0000_0080);
        run_load("lh",  64'h8000_0006, 3'b001, 5'd7,  64'h8001_0000_0000_0000,
                 64'h8000_0000, 64'hFFFF_FFFF_FFFF_8001);
        run_load("lw",  64'h8000_000C, 3'b010, 5'd8,  64'hDEAD_BEEF_1234_5678,
                 64'h8000_0008, 64'hFFFF_FFFF_DEAD_BEEF);
        run_load("lwu", 64'h8000_000C, 3'b110, 5'd9,  64'hDEAD_BEEF_1234_5678,
                 64'h8000_0008, 64'h0000_0000_DEAD_BEEF);
        run_load("ld",  64'h8000_0018, 3'b011, 5'd10, 64'h8123_4567_89AB_CDEF,
                 64'h8000_0018, 64'h8123_4567_89AB_CDEF);
        run_load("ldu", 64'h8000_0018, 3'b111, 5'd11, 64'h8123_4567_89AB_CDEF,
                 64'h8000_0018, 64'h8123_4567_89AB_CDEF);

        // Misaligned LW: no memory request, flagged result one cycle after accept.
        @(negedge clock);
        in_valid = 1'b1; in_addr = 64'h8000_0002; in_wen = 1'b0; in_lsu_type = 3'b010; in_rd = 5'd12;
        @(negedge clock);
        in_valid = 1'b0;
        chk("mis_req_valid", 64'(mem_req_valid), 64'd0);
        chk("mis_out_valid", 64'(out_valid), 64'd1);
        chk("mis_flag", 64'(out_misalign), 64'd1);
        chk("mis_out_data", out_data, 64'd0);
        chk("mis_out_rd", 64'(out_rd), 64'd12);
        @(negedge clock);
        chk("mis_done", 64'(out_valid), 64'd0);
        chk("mis_req_still_low", 64'(mem_req_valid), 64'd0);

        // Store half: shifted data, byte mask, result two cycles after accept.
        @(negedge clock);
        in_valid = 1'b1; in_addr = 64'h8000_0006; in_wen = 1'b1; in_wdata = 64'h0000_0000_0000_BEEF;
        in_lsu_type = 3'b001; in_rd = 5'd13; mem_req_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk("sh_req_valid", 64'(mem_req_valid), 64'd1);
        chk("sh_mem_addr", mem_addr, 64'h8000_0000);
        chk("sh_mem_wen", 64'(mem_wen), 64'd1);
        chk("sh_mem_wmask", 64'(mem_wmask), 64'h00C0);
        chk("sh_mem_wdata", mem_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_early_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        chk("sh_out_valid", 64'(out_valid), 64'd1);
        chk("sh_out_data", out_data, 64'd0);
        chk("sh_req_dropped", 64'(mem_req_valid), 64'd0);
        @(negedge clock);
        chk("sh_idle", 64'(in_ready), 64'd1);

        // Stray response while idle must not produce a result.
        mem_resp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("stray_idle_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: request held 5 cycles, then result held 3 cycles.
        in_valid = 1'b1; in_addr = 64'h8000_0010; in_wen = 1'b0; in_lsu_type = 3'b010; in_rd = 5'd9;
        mem_req_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", 64'(mem_req_valid), 64'd1);
            chk("bp_mem_addr", mem_addr, 64'h8000_0010);
            chk("bp_mem_wmask", 64'(mem_wmask), 64'h000F);
            chk("bp_mem_wen", 64'(mem_wen), 64'd0);
            mem_resp_valid = (i == 2);
            mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
            if (i == 4) mem_req_ready = 1'b1;
            @(negedge clock);
        end
        mem_req_ready = 1'b0;
        chk("bp_wait_no_req", 64'(mem_req_valid), 64'd0);
        chk("bp_wait_no_out", 64'(out_valid), 64'd0);
        mem_resp_valid = 1'b1; mem_rdata = 64'h1111_2222_7FFF_1234; out_ready = 1'b0;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", out_data, 64'h0000_0000_7FFF_1234);
            chk("bp_out_rd", 64'(out_rd), 64'd9);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            if (i == 2) out_ready = 1'b1;
            @(negedge clock);
        end
        chk("bp_released", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(in_ready), 64'd1);

        // Reset asserted while waiting for load data.
        in_valid = 1'b1; in_addr = 64'h8000_0020; in_wen = 1'b0; in_lsu_type = 3'b011; in_rd = 5'd14;
        mem_req_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("rw_in_wait_req", 64'(mem_req_valid), 64'd0);
        chk("rw_in_wait_ready", 64'(in_ready), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rw_async_in_ready", 64'(in_ready), 64'd1);
        chk("rw_async_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rw_async_out_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("rw_resp_ignored_valid", 64'(out_valid), 64'd0);
        chk("rw_resp_ignored_data", out_data, 64'd0);
        chk("rw_idle", 64'(in_ready), 64'd1);

`ifdef LSU_TIMEOUT_EN
        // No response: watchdog fires four cycles after entering WAIT.
        in_valid = 1'b1; in_addr = 64'h8000_0030; in_wen = 1'b0; in_lsu_type = 3'b010; in_rd = 5'd15;
        mem_req_ready = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            chk("to_waiting", 64'(out_valid), 64'd0);
            @(negedge clock);
        end
        chk("to_out_valid", 64'(out_valid), 64'd1);
        chk("to_out_timeout", 64'(out_timeout), 64'd1);
        chk("to_out_data", out_data, 64'd0);
        @(negedge clock);
        chk("to_idle", 64'(in_ready), 64'd1);
`else
        chk("no_watchdog_timeout", 64'(out_timeout), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
